hazard_scoreboard: RTL and testbench

- Parametrised successor to the combinational ID-stage stall detector. Tracks every in-flight register writer in a DEPTH-entry shift scoreboard, not just two fixed ID/EX stage snapshots.
- Computes ID-stage stall from per-producer readiness latency, per-consumer operand timing (normal, early branch/JR, late store data), a memory-busy freeze and a flush.
- Sits between decode and the ID/EX pipeline register; drives the PC/IF-ID hold and the EX bubble insert.

---
 rtl/hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// ID-stage stall detector built around a DEPTH-entry shift scoreboard of
// in-flight register writers. Entry 0 is the instruction in EX, entry 1 is in
// MEM, entry 2 is in WB. Older producers have already reached the write-through
// register file, so they never cause a hazard.
//
// Each scoreboard entry records:
//   vld  : the instruction writes a register
//   dest : destination register index
//   ld   : the result comes from a load
//
// An operand stalls when a matching entry k has not yet aged enough entries
// for that consumer to take the result (k < need). The value of need depends
// on the producer (ALU or load) and on the consumer timing (normal, early in
// ID, or late store data in MEM).
//
// Optional feature (macro STALL_STATS_EN):
//   defined   : saturating stall_cycles and load_use_events counters
//   undefined : no counter flops; both counter ports read 16'h0000
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   id_valid        in   ID holds a real instruction
//   id_rs/_vld      in   source register 1 and its read enable
//   id_rt/_vld      in   source register 2 and its read enable
//   id_rt_late      in   rt is consumed in MEM (store data)
//   id_early        in   operands are needed in ID (branch, JR/JALR)
//   id_wr_en        in   instruction writes a register
//   id_dest         in   destination register
//   id_is_load      in   destination is written by a load
//   mem_busy        in   memory wait; the whole pipeline freezes
//   flush           in   squash the youngest FLUSH_STAGES entries
//   stall           out  hold PC and IF/ID
//   ex_bubble       out  insert a NOP into ID/EX
//   pending         out  bit r set while a valid entry targets register r
//   stall_cycles    out  saturating count of stalled cycles
//   load_use_events out  saturating count of load-use stall episodes
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_W        = 3,
    parameter int DEPTH        = 3,
    parameter int ALU_LAT      = 0,
    parameter int LD_LAT       = 1,
    parameter int EARLY_EXTRA  = 1,
    parameter int FLUSH_STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_W-1:0]        id_rs,
    input  logic                    id_rs_vld,
    input  logic [REG_W-1:0]        id_rt,
    input  logic                    id_rt_vld,
    input  logic                    id_rt_late,
    input  logic                    id_early,
    input  logic                    id_wr_en,
    input  logic [REG_W-1:0]        id_dest,
    input  logic                    id_is_load,
    input  logic                    mem_busy,
    input  logic                    flush,
    output logic                    stall,
    output logic                    ex_bubble,
    output logic [(2**REG_W)-1:0]   pending,
    output logic [15:0]             stall_cycles,
    output logic [15:0]             load_use_events
);

    localparam int NUM_REGS = 2 ** REG_W;

    // Number of entries actually cleared by a flush (cannot exceed DEPTH).
    localparam int FLUSH_N = (FLUSH_STAGES < DEPTH) ? FLUSH_STAGES : DEPTH;

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0] vld_reg;
    logic [DEPTH-1:0] ld_reg;
    logic [REG_W-1:0] dest_reg [DEPTH];

    logic [DEPTH-1:0] vld_next;
    logic [DEPTH-1:0] ld_next;
    logic [REG_W-1:0] dest_next [DEPTH];

    // Per-entry hazard flags for each operand.
    logic [DEPTH-1:0] hz_rs;
    logic [DEPTH-1:0] hz_rt;

    logic raw_stall;
    logic issue;

    // -------------------------------------------------------------------------
    // Per-entry readiness check
    //
    // The latency is taken from the entry that matches, so a load and an ALU
    // op targeting the same register in different entries are judged
    // independently and the results are ORed (older matches are never
    // masked by younger ones).
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] base_lat;
            logic [31:0] need_rs;
            logic [31:0] need_rt;

            assign base_lat = ld_reg[gi] ? 32'(LD_LAT) : 32'(ALU_LAT);

            assign need_rs = base_lat + (id_early ? 32'(EARLY_EXTRA) : 32'd0);

            // Store data is consumed one stage later, so it needs one entry
            // less; early resolution does not apply to it.
            assign need_rt = id_rt_late
                           ? ((base_lat == 32'd0) ? 32'd0 : base_lat - 32'd1)
                           : need_rs;

            assign hz_rs[gi] = vld_reg[gi] & id_rs_vld
                             & (dest_reg[gi] == id_rs)
                             & (32'(gi) < need_rs);

            assign hz_rt[gi] = vld_reg[gi] & id_rt_vld
                             & (dest_reg[gi] == id_rt)
                             & (32'(gi) < need_rt);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stall / bubble / issue
    // -------------------------------------------------------------------------
    assign raw_stall = id_valid & (|(hz_rs | hz_rt));

    // A memory wait freezes everything, including ID/EX, so no bubble is
    // inserted while it lasts.
    assign stall     = raw_stall | mem_busy;
    assign ex_bubble = raw_stall & ~mem_busy;
    assign issue     = id_valid & ~stall & ~flush;

    // -------------------------------------------------------------------------
    // Pending-register vector
    // -------------------------------------------------------------------------
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_reg[k]) begin
                pending[dest_reg[k]] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: shift (or hold on mem_busy), then apply flush on top
    // -------------------------------------------------------------------------
    always_comb begin
        vld_next  = vld_reg;
        ld_next   = ld_reg;
        dest_next = dest_reg;

        if (!mem_busy) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_next[k]  = vld_reg[k-1];
                ld_next[k]   = ld_reg[k-1];
                dest_next[k] = dest_reg[k-1];
            end
            // Non-writers and bubbles both enter as invalid entries.
            vld_next[0]  = issue & id_wr_en;
            ld_next[0]   = id_is_load;
            dest_next[0] = id_dest;
        end

        // Flush squashes after the shift/hold, so with a frozen pipeline it
        // removes the instruction that is sitting in EX.
        if (flush) begin
            for (int k = 0; k < FLUSH_N; k++) begin
                vld_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            ld_reg  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_reg[k] <= '0;
            end
        end else begin
            vld_reg <= vld_next;
            ld_reg  <= ld_next;
            for (int k = 0; k < DEPTH; k++) begin
                dest_reg[k] <= dest_next[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef STALL_STATS_EN
    logic        raw_prev_reg;
    logic [15:0] stall_cycles_reg;
    logic [15:0] load_use_reg;
    logic        ld_hazard;

    // A load-use episode is one whose stall is caused by a load entry.
    assign ld_hazard = |((hz_rs | hz_rt) & ld_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_prev_reg     <= 1'b0;
            stall_cycles_reg <= 16'h0000;
            load_use_reg     <= 16'h0000;
        end else begin
            raw_prev_reg <= raw_stall;
            if (stall && (stall_cycles_reg != 16'hFFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            end
            // Count only the first cycle of a stall episode.
            if (raw_stall && !raw_prev_reg && ld_hazard
                && (load_use_reg != 16'hFFFF)) begin
                load_use_reg <= load_use_reg + 16'd1;
            end
        end
    end

    assign stall_cycles    = stall_cycles_reg;
    assign load_use_events = load_use_reg;
`else
    assign stall_cycles    = 16'h0000;
    assign load_use_events = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int REG_W        = 3;
    localparam int DEPTH        = 3;
    localparam int ALU_LAT      = 0;
    localparam int LD_LAT       = 1;
    localparam int EARLY_EXTRA  = 1;
    localparam int FLUSH_STAGES = 1;
    localparam int NUM_REGS     = 8;

`ifdef STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid;
    logic [REG_W-1:0]    id_rs;
    logic                id_rs_vld;
    logic [REG_W-1:0]    id_rt;
    logic                id_rt_vld;
    logic                id_rt_late;
    logic                id_early;
    logic                id_wr_en;
    logic [REG_W-1:0]    id_dest;
    logic                id_is_load;
    logic                mem_busy;
    logic                flush;
    logic                stall;
    logic                ex_bubble;
    logic [NUM_REGS-1:0] pending;
    logic [15:0]         stall_cycles;
    logic [15:0]         load_use_events;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: list of in-flight writers, each tagged with its age
    // in pipeline advances since issue.
    typedef struct {
        int dest;
        bit ld;
        int age;
    } prod_t;

    prod_t q[$];
    int    m_stall_cnt;
    int    m_lu_cnt;
    bit    m_raw_prev;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rs_vld       (id_rs_vld),
        .id_rt           (id_rt),
        .id_rt_vld       (id_rt_vld),
        .id_rt_late      (id_rt_late),
        .id_early        (id_early),
        .id_wr_en        (id_wr_en),
        .id_dest         (id_dest),
        .id_is_load      (id_is_load),
        .mem_busy        (mem_busy),
        .flush           (flush),
        .stall           (stall),
        .ex_bubble       (ex_bubble),
        .pending         (pending),
        .stall_cycles    (stall_cycles),
        .load_use_events (load_use_events)
    );

    // Cycles a producer must age before this consumer operand may read it.
    function automatic int need_of(input bit ld, input bit is_rt);
        int base;
        base = ld ? LD_LAT : ALU_LAT;
        if (is_rt && id_rt_late) return (base > 0) ? base - 1 : 0;
        return base + (id_early ? EARLY_EXTRA : 0);
    endfunction

    task automatic model_hazard(output bit raw, output bit ldh);
        raw = 1'b0;
        ldh = 1'b0;
        foreach (q[i]) begin
            if (id_rs_vld && q[i].dest == int'(id_rs) && q[i].age < need_of(q[i].ld, 1'b0)) begin
                raw = 1'b1;
                if (q[i].ld) ldh = 1'b1;
            end
            if (id_rt_vld && q[i].dest == int'(id_rt) && q[i].age < need_of(q[i].ld, 1'b1)) begin
                raw = 1'b1;
                if (q[i].ld) ldh = 1'b1;
            end
        end
        raw = raw & id_valid;
        ldh = ldh & id_valid;
    endtask

    function automatic logic [NUM_REGS-1:0] model_pending();
        logic [NUM_REGS-1:0] p;
        p = '0;
        foreach (q[i]) p[q[i].dest] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_stall_cnt = 0;
        m_lu_cnt    = 0;
        m_raw_prev  = 1'b0;
    endtask

    task automatic model_edge();
        bit    raw, ldh, st, iss;
        prod_t keep[$];
        prod_t p;
        model_hazard(raw, ldh);
        st  = raw | mem_busy;
        iss = id_valid & ~st & ~flush;
        if (st && m_stall_cnt < 65535) m_stall_cnt++;
        if (raw && !m_raw_prev && ldh && m_lu_cnt < 65535) m_lu_cnt++;
        m_raw_prev = raw;
        if (!mem_busy) begin
            keep.delete();
            foreach (q[i]) begin
                p = q[i];
                p.age++;
                if (p.age < DEPTH) keep.push_back(p);
            end
            q = keep;
            if (iss && id_wr_en) begin
                p.dest = int'(id_dest);
                p.ld   = id_is_load;
                p.age  = 0;
                q.push_back(p);
            end
        end
        if (flush) begin
            keep.delete();
            foreach (q[i]) if (q[i].age >= FLUSH_STAGES) keep.push_back(q[i]);
            q = keep;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit raw, ldh;
        model_hazard(raw, ldh);
        check("stall",     16'(stall),           16'(raw | mem_busy));
        check("ex_bubble", 16'(ex_bubble),       16'(raw & ~mem_busy));
        check("pending",   16'(pending),         16'(model_pending()));
        check("stall_cyc", stall_cycles,         STATS ? 16'(m_stall_cnt) : 16'h0);
        check("load_use",  load_use_events,      STATS ? 16'(m_lu_cnt)    : 16'h0);
    endtask

    task automatic settle();
        #1;
    endtask

    // Assumes settle() has already been called after driving inputs.
    task automatic step();
        check_outputs();
        $display("t=%0t valid=%0b rs=%0d/%0b rt=%0d/%0b late=%0b early=%0b wr=%0b dest=%0d ld=%0b busy=%0b flush=%0b -> stall=%0b bub=%0b pend=%02h",
                 $time, id_valid, id_rs, id_rs_vld, id_rt, id_rt_vld, id_rt_late, id_early,
                 id_wr_en, id_dest, id_is_load, mem_busy, flush, stall, ex_bubble, pending);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic nop();
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rs_vld  = 1'b0;
        id_rt      = '0;
        id_rt_vld  = 1'b0;
        id_rt_late = 1'b0;
        id_early   = 1'b0;
        id_wr_en   = 1'b0;
        id_dest    = '0;
        id_is_load = 1'b0;
        mem_busy   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic producer(input int dest, input bit ld);
        nop();
        id_valid   = 1'b1;
        id_wr_en   = 1'b1;
        id_dest    = REG_W'(dest);
        id_is_load = ld;
    endtask

    task automatic consumer_rs(input int rs, input bit early);
        nop();
        id_valid  = 1'b1;
        id_rs     = REG_W'(rs);
        id_rs_vld = 1'b1;
        id_early  = early;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        model_reset();
        #12;
        check("rst_stall",   16'(stall),     16'd0);
        check("rst_bubble",  16'(ex_bubble), 16'd0);
        check("rst_pending", 16'(pending),   16'd0);
        check("rst_stc",     stall_cycles,   16'd0);
        check("rst_lue",     load_use_events,16'd0);
        rst_n = 1'b1;
        settle();
        step();

        // Load R6, consumer waits through a 3-cycle memory freeze.
        producer(6, 1'b1); settle(); step();
        consumer_rs(6, 1'b0);
        id_rt = 3'd1; id_rt_vld = 1'b1; id_wr_en = 1'b1; id_dest = 3'd2;
        mem_busy = 1'b1;
        repeat (3) begin
            settle();
            check("busy_stall",  16'(stall),     16'd1);
            check("busy_bubble", 16'(ex_bubble), 16'd0);
            check("busy_pend6",  16'(pending[6]),16'd1);
            step();
        end
        mem_busy = 1'b0;
        settle();
        check("post_busy_stall",  16'(stall),     16'd1);
        check("post_busy_bubble", 16'(ex_bubble), 16'd1);
        step();
        settle();
        check("post_busy_issue", 16'(stall), 16'd0);
        step();
        nop(); settle();
        check("busy_stall_cycles", stall_cycles,    STATS ? 16'd4 : 16'd0);
        check("busy_load_use",     load_use_events, STATS ? 16'd1 : 16'd0);
        step(); step(); step();

        // Load R1 then ADD R2,R1,R3: one stall.
        producer(1, 1'b1); settle(); step();
        consumer_rs(1, 1'b0); id_rt = 3'd3; id_rt_vld = 1'b1; id_wr_en = 1'b1; id_dest = 3'd2;
        settle();
        check("lu_stall",  16'(stall),     16'd1);
        check("lu_bubble", 16'(ex_bubble), 16'd1);
        step();
        settle();
        check("lu_issue", 16'(stall), 16'd0);
        step();

        // ALU R4 then BEQZ R4: one stall.
        producer(4, 1'b0); settle(); step();
        consumer_rs(4, 1'b1); settle();
        check("alu_br_stall", 16'(stall), 16'd1);
        step();
        settle();
        check("alu_br_issue", 16'(stall), 16'd0);
        step();

        // Load R4 then BEQZ R4: two stalls, load still pending at issue.
        nop(); settle(); step(); step();
        producer(4, 1'b1); settle(); step();
        consumer_rs(4, 1'b1);
        repeat (2) begin
            settle();
            check("ld_br_stall", 16'(stall), 16'd1);
            step();
        end
        settle();
        check("ld_br_issue", 16'(stall),      16'd0);
        check("ld_br_pend4", 16'(pending[4]), 16'd1);
        step();

        // Load R5 then store data R5: no stall.
        producer(5, 1'b1); settle(); step();
        nop(); id_valid = 1'b1; id_rs = 3'd2; id_rs_vld = 1'b1;
        id_rt = 3'd5; id_rt_vld = 1'b1; id_rt_late = 1'b1;
        settle();
        check("st_data_stall", 16'(stall), 16'd0);
        step();

        // Load R5 then store address R5: one stall.
        producer(5, 1'b1); settle(); step();
        consumer_rs(5, 1'b0); id_rt = 3'd0; id_rt_vld = 1'b1; id_rt_late = 1'b1;
        settle();
        check("st_addr_stall", 16'(stall), 16'd1);
        step();
        settle();
        check("st_addr_issue", 16'(stall), 16'd0);
        step();

        // rs == rt on a fresh load: single one-cycle stall.
        producer(3, 1'b1); settle(); step();
        consumer_rs(3, 1'b0); id_rt = 3'd3; id_rt_vld = 1'b1;
        settle(); step(); settle(); step();

        // Load R7 in EX, flush while frozen clears it.
        nop(); settle(); step(); step(); step();
        producer(7, 1'b1); settle(); step();
        nop(); mem_busy = 1'b1; flush = 1'b1; settle(); step();
        consumer_rs(7, 1'b0); settle();
        check("flush_pend7", 16'(pending[7]), 16'd0);
        check("flush_stall", 16'(stall),      16'd0);
        step();

        // Flush on the issuing cycle suppresses issue.
        producer(2, 1'b0); flush = 1'b1; settle(); step();
        nop(); settle();
        check("flush_noissue", 16'(pending[2]), 16'd0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = REG_W'($urandom_range(0, NUM_REGS - 1));
            id_rs_vld  = $urandom_range(0, 1) == 1;
            id_rt      = REG_W'($urandom_range(0, NUM_REGS - 1));
            id_rt_vld  = $urandom_range(0, 1) == 1;
            id_rt_late = ($urandom_range(0, 3) == 0);
            id_early   = ($urandom_range(0, 3) == 0);
            id_wr_en   = ($urandom_range(0, 3) != 0);
            id_dest    = REG_W'($urandom_range(0, NUM_REGS - 1));
            id_is_load = $urandom_range(0, 1) == 1;
            mem_busy   = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            settle();
            step();
        end

        // Asynchronous reset in the middle of a stall.
        producer(1, 1'b1); settle(); step();
        consumer_rs(1, 1'b0); settle();
        check("pre_rst_stall", 16'(stall), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall",   16'(stall),      16'd0);
        check("arst_pending", 16'(pending),    16'd0);
        check("arst_stc",     stall_cycles,    16'd0);
        check("arst_lue",     load_use_events, 16'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        nop();
        settle(); step();
        producer(6, 1'b1); settle(); step();
        consumer_rs(6, 1'b0); settle(); step(); settle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
